// File: rtl/d_register_bank_mp.sv
// Multi-port register bank: NUM_RD combinational reads, two prioritised write ports and a DEPTH-cycle clear sweep.
// Optional macro REGBANK_BYPASS_EN forwards same-cycle write data to matching reads.
module d_register_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD*AW-1:0]     i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    input  logic                     i_we0,
    input  logic [AW-1:0]            i_waddr0,
    input  logic [DATA_W-1:0]        i_wdata0,
    input  logic                     i_we1,
    input  logic [AW-1:0]            i_waddr1,
    input  logic [DATA_W-1:0]        i_wdata1,
    input  logic                     i_clr,
    output logic                     o_ready
);
    typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    state_t            r_state;
    logic [AW:0]       r_idx;
    logic              r_ready;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic w_wr0_ok;
    logic w_wr1_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < LP_DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Port 0 loses to port 1 on an address collision.
    assign w_wr1_ok = (r_state == ST_RUN) && i_we1 && addr_ok(i_waddr1);
    assign w_wr0_ok = (r_state == ST_RUN) && i_we0 && addr_ok(i_waddr0) &&
                      !(i_we1 && (i_waddr1 == i_waddr0));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wr0_ok) r_regs[i_waddr0] <= i_wdata0;
                    if (w_wr1_ok) r_regs[i_waddr1] <= i_wdata1;
                    if (i_clr) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_regs[r_idx[AW-1:0]] <= '0;
                    r_idx <= r_idx + LP_ONE;
                    if (r_idx == LP_LAST) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    function automatic logic [DATA_W-1:0] rd_val(input logic [AW-1:0] a);
        logic [DATA_W-1:0] v;
        v = addr_ok(a) ? r_regs[a] : '0;
`ifdef REGBANK_BYPASS_EN
        if (w_wr0_ok && (a == i_waddr0)) v = i_wdata0;
        if (w_wr1_ok && (a == i_waddr1)) v = i_wdata1;
`endif
        // A half-swept bank must never be observed.
        if (r_state != ST_RUN) v = '0;
        return v;
    endfunction

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            o_rd_data[k*DATA_W +: DATA_W] = rd_val(i_rd_addr[k*AW +: AW]);
        end
    end

    assign o_ready = r_ready;

endmodule

// File: tb/tb_d_register_bank_mp.sv
// Bench for d_register_bank_mp: instance A uses defaults, instance B uses DEPTH=20, NUM_RD=3, ZERO_REG=0.
module tb_d_register_bank_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic        a_we0, a_we1, a_clr, a_ready;
    logic [4:0]  a_waddr0, a_waddr1;
    logic [31:0] a_wdata0, a_wdata1;

    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic        b_we0, b_we1, b_clr, b_ready;
    logic [4:0]  b_waddr0, b_waddr1;
    logic [31:0] b_wdata0, b_wdata1;

    d_register_bank_mp u_a (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
        .i_we0(a_we0), .i_waddr0(a_waddr0), .i_wdata0(a_wdata0),
        .i_we1(a_we1), .i_waddr1(a_waddr1), .i_wdata1(a_wdata1),
        .i_clr(a_clr), .o_ready(a_ready)
    );

    d_register_bank_mp #(.DATA_W(32), .DEPTH(20), .NUM_RD(3), .ZERO_REG(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
        .i_we0(b_we0), .i_waddr0(b_waddr0), .i_wdata0(b_wdata0),
        .i_we1(b_we1), .i_waddr1(b_waddr1), .i_wdata1(b_wdata1),
        .i_clr(b_clr), .o_ready(b_ready)
    );

    // Reference: stored contents plus cycles of clear remaining (reads are 0 and writes ignored while > 0).
    logic [31:0] ma [32];
    logic [31:0] mb [20];
    int ca_left, cb_left;

    function automatic logic [31:0] exp_a(input int addr);
        logic [31:0] v;
        if (ca_left > 0) return 32'h0;
        v = (addr == 0 || addr >= 32) ? 32'h0 : ma[addr];
`ifdef REGBANK_BYPASS_EN
        if (a_we0 && int'(a_waddr0) == addr && addr != 0) v = a_wdata0;
        if (a_we1 && int'(a_waddr1) == addr && addr != 0) v = a_wdata1;
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_b(input int addr);
        logic [31:0] v;
        if (cb_left > 0) return 32'h0;
        v = (addr >= 20) ? 32'h0 : mb[addr];
`ifdef REGBANK_BYPASS_EN
        if (b_we0 && int'(b_waddr0) == addr && addr < 20) v = b_wdata0;
        if (b_we1 && int'(b_waddr1) == addr && addr < 20) v = b_wdata1;
`endif
        return v;
    endfunction

    task automatic model_reset();
        foreach (ma[i]) ma[i] = 32'h0;
        foreach (mb[i]) mb[i] = 32'h0;
        ca_left = 0;
        cb_left = 0;
    endtask

    task automatic idle();
        a_we0 = 0; a_we1 = 0; a_clr = 0;
        b_we0 = 0; b_we1 = 0; b_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (ca_left > 0) ca_left--;
            else begin
                if (a_we0 && a_waddr0 != 0) ma[a_waddr0] = a_wdata0;
                if (a_we1 && a_waddr1 != 0) ma[a_waddr1] = a_wdata1;
                if (a_clr) begin foreach (ma[i]) ma[i] = 32'h0; ca_left = 32; end
            end
            if (cb_left > 0) cb_left--;
            else begin
                if (b_we0 && b_waddr0 < 20) mb[b_waddr0] = b_wdata0;
                if (b_we1 && b_waddr1 < 20) mb[b_waddr1] = b_wdata1;
                if (b_clr) begin foreach (mb[i]) mb[i] = 32'h0; cb_left = 20; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        a_waddr0 = 0; a_waddr1 = 0; a_wdata0 = 0; a_wdata1 = 0;
        b_waddr0 = 0; b_waddr1 = 0; b_wdata0 = 0; b_wdata1 = 0;
        a_rd_addr = {5'd7, 5'd5};
        b_rd_addr = {5'd19, 5'd3, 5'd1};
        model_reset();
        #3;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_a_ready got=%0b exp=1", a_ready); end
        tests++; if (a_rd_data !== 64'h0) begin fails++; $display("FAIL reset_a_rd got=%h exp=0", a_rd_data); end
        tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL reset_b_ready got=%0b exp=1", b_ready); end
        tests++; if (b_rd_data !== 96'h0) begin fails++; $display("FAIL reset_b_rd got=%h exp=0", b_rd_data); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic [31:0] exp_during;
`ifdef REGBANK_BYPASS_EN
        exp_during = 32'hDEADBEEF;
`else
        exp_during = 32'h0;
`endif
        a_we0 = 1; a_waddr0 = 5'd5; a_wdata0 = 32'hDEADBEEF;
        a_rd_addr = {5'd5, 5'd0};
        #1;
        tests++; if (a_rd_data[63:32] !== exp_during) begin fails++; $display("FAIL wr_same_cycle got=%h exp=%h", a_rd_data[63:32], exp_during); end
        tick(); idle(); #1;
        tests++; if (a_rd_data[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_next_cycle got=%h exp=deadbeef", a_rd_data[63:32]); end
    endtask

    task automatic test_collision();
        a_we0 = 1; a_waddr0 = 5'd9; a_wdata0 = 32'h11111111;
        a_we1 = 1; a_waddr1 = 5'd9; a_wdata1 = 32'h22222222;
        tick(); idle();
        a_rd_addr = {5'd0, 5'd9};
        #1;
        tests++; if (a_rd_data[31:0] !== 32'h22222222) begin fails++; $display("FAIL collision got=%h exp=22222222", a_rd_data[31:0]); end
        a_we0 = 1; a_waddr0 = 5'd3; a_wdata0 = 32'hA;
        a_we1 = 1; a_waddr1 = 5'd4; a_wdata1 = 32'hB;
        tick(); idle();
        a_rd_addr = {5'd4, 5'd3};
        #1;
        tests++; if (a_rd_data[31:0] !== 32'hA) begin fails++; $display("FAIL dual_wr_p0 got=%h exp=a", a_rd_data[31:0]); end
        tests++; if (a_rd_data[63:32] !== 32'hB) begin fails++; $display("FAIL dual_wr_p1 got=%h exp=b", a_rd_data[63:32]); end
    endtask

    task automatic test_zero_reg();
        a_we0 = 1; a_waddr0 = 5'd0; a_wdata0 = 32'hFFFFFFFF;
        a_rd_addr = {5'd0, 5'd0};
        #1;
        tests++; if (a_rd_data !== 64'h0) begin fails++; $display("FAIL zero_reg_during got=%h exp=0", a_rd_data); end
        tick(); idle(); #1;
        tests++; if (a_rd_data !== 64'h0) begin fails++; $display("FAIL zero_reg_after got=%h exp=0", a_rd_data); end
        b_we1 = 1; b_waddr1 = 5'd0; b_wdata1 = 32'hFFFFFFFF;
        tick(); idle();
        b_rd_addr = {5'd0, 5'd0, 5'd0};
        #1;
        tests++; if (b_rd_data[31:0] !== 32'hFFFFFFFF) begin fails++; $display("FAIL plain_reg0 got=%h exp=ffffffff", b_rd_data[31:0]); end
    endtask

    task automatic test_clear();
        int low;
        for (int i = 1; i < 32; i++) begin
            a_we0 = 1; a_waddr0 = 5'(i); a_wdata0 = 32'(i);
            tick();
        end
        idle();
        a_rd_addr = {5'd31, 5'd7};
        #1;
        tests++; if (a_rd_data !== {32'd31, 32'd7}) begin fails++; $display("FAIL fill_readback got=%h exp=%h", a_rd_data, {32'd31, 32'd7}); end
        a_clr = 1;
        tick(); idle();
        low = 0;
        while (a_ready === 1'b0 && low < 40) begin
            low++;
            if (low == 10) begin
                a_we0 = 1; a_waddr0 = 5'd7; a_wdata0 = 32'h1234; a_clr = 1;
                #1;
                tests++; if (a_rd_data !== 64'h0) begin fails++; $display("FAIL clear_mid_read got=%h exp=0", a_rd_data); end
            end
            tick(); idle();
        end
        tests++; if (low != 32) begin fails++; $display("FAIL clear_ready_low_cycles got=%0d exp=32", low); end
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL clear_ready_after got=%0b exp=1", a_ready); end
        for (int r = 0; r < 32; r += 2) begin
            a_rd_addr = {5'(r + 1), 5'(r)};
            #1;
            tests++; if (a_rd_data !== 64'h0) begin fails++; $display("FAIL clear_readback r%0d got=%h exp=0", r, a_rd_data); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 6; i++) begin
            a_we1 = 1; a_waddr1 = 5'(i); a_wdata1 = 32'(i * 3 + 1);
            tick();
        end
        idle();
        a_clr = 1;
        tick(); idle();
        repeat (9) tick();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        a_rd_addr = {5'd3, 5'd1};
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL async_rst_ready got=%0b exp=1", a_ready); end
        tests++; if (a_rd_data !== 64'h0) begin fails++; $display("FAIL async_rst_rd got=%h exp=0", a_rd_data); end
        a_we0 = 1; a_waddr0 = 5'd2; a_wdata0 = 32'h55;
        #1;
        rst = 1'b0;
        tick(); idle();
        a_rd_addr = {5'd2, 5'd2};
        #1;
        tests++; if (a_rd_data[31:0] !== 32'h55) begin fails++; $display("FAIL post_rst_write got=%h exp=55", a_rd_data[31:0]); end
    endtask

    task automatic test_depth20();
        b_we0 = 1; b_waddr0 = 5'd25; b_wdata0 = 32'h77;
        tick(); idle();
        b_rd_addr = {5'd25, 5'd25, 5'd25};
        #1;
        tests++; if (b_rd_data !== 96'h0) begin fails++; $display("FAIL oob_read got=%h exp=0", b_rd_data); end
        b_we1 = 1; b_waddr1 = 5'd19; b_wdata1 = 32'h5A;
        tick(); idle();
        b_rd_addr = {5'd19, 5'd19, 5'd19};
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (b_rd_data[k*32 +: 32] !== 32'h5A) begin fails++; $display("FAIL top_reg_port%0d got=%h exp=5a", k, b_rd_data[k*32 +: 32]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            a_we0 = ($urandom_range(0, 2) != 0); a_waddr0 = 5'($urandom_range(0, 31)); a_wdata0 = $urandom;
            a_we1 = ($urandom_range(0, 2) != 0); a_waddr1 = 5'($urandom_range(0, 31)); a_wdata1 = $urandom;
            if ($urandom_range(0, 4) == 0) a_waddr1 = a_waddr0;
            a_clr = ($urandom_range(0, 60) == 0);
            a_rd_addr = {5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0) ? a_waddr0 : 5'($urandom_range(0, 31))};
            b_we0 = ($urandom_range(0, 2) != 0); b_waddr0 = 5'($urandom_range(0, 31)); b_wdata0 = $urandom;
            b_we1 = ($urandom_range(0, 2) != 0); b_waddr1 = 5'($urandom_range(0, 31)); b_wdata1 = $urandom;
            if ($urandom_range(0, 4) == 0) b_waddr1 = b_waddr0;
            b_clr = ($urandom_range(0, 60) == 0);
            b_rd_addr = {5'($urandom_range(0, 31)), b_waddr1, ($urandom_range(0, 2) == 0) ? b_waddr0 : 5'($urandom_range(0, 31))};
            #1;
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (a_rd_data[k*32 +: 32] !== exp_a(int'(a_rd_addr[k*5 +: 5]))) begin
                    fails++; $display("FAIL rand_a_rd n%0d p%0d got=%h exp=%h", n, k, a_rd_data[k*32 +: 32], exp_a(int'(a_rd_addr[k*5 +: 5])));
                end
            end
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (b_rd_data[k*32 +: 32] !== exp_b(int'(b_rd_addr[k*5 +: 5]))) begin
                    fails++; $display("FAIL rand_b_rd n%0d p%0d got=%h exp=%h", n, k, b_rd_data[k*32 +: 32], exp_b(int'(b_rd_addr[k*5 +: 5])));
                end
            end
            tests++; if (a_ready !== (ca_left == 0)) begin fails++; $display("FAIL rand_a_ready n%0d got=%0b exp=%0b", n, a_ready, ca_left == 0); end
            tests++; if (b_ready !== (cb_left == 0)) begin fails++; $display("FAIL rand_b_ready n%0d got=%0b exp=%0b", n, b_ready, cb_left == 0); end
            tick();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_clear();
        test_async_reset();
        test_depth20();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/d_register_bank_mp.md
Name: d_register_bank_mp

Overview:
- Parametrised, multi-port successor to the decode-stage register bank.
- Provides NUM_RD combinational read ports and two synchronous write ports with defined collision priority.
- Register 0 is optionally hardwired to zero.
- A clear sequencer zeroes the whole bank on request without a full reset, stalling the pipeline through o_ready while it runs.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; any value from 2 to 256.
- NUM_RD, 2, number of read ports; 1 to 4.
- ZERO_REG, 1, 1 hardwires register 0 to zero; 0 makes it an ordinary register.
- AW, $clog2(DEPTH), address width; derived, do not override.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rd_addr  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW].
- o_rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- i_we0  in  1  write enable, port 0.
- i_waddr0  in  AW  write address, port 0.
- i_wdata0  in  DATA_W  write data, port 0.
- i_we1  in  1  write enable, port 1.
- i_waddr1  in  AW  write address, port 1.
- i_wdata1  in  DATA_W  write data, port 1.
- i_clr  in  1  single-cycle clear request.
- o_ready  out  1  1 = bank accepting writes; 0 = clear in progress.

Behaviour:
- Reset:
  - i_rst high clears every register to 0 immediately, without waiting for a clock edge.
  - FSM goes to RUN, clear index goes to 0, o_ready = 1.
  - o_rd_data is 0 on all ports while reset is held.
- Reads:
  - Purely combinational, zero latency: o_rd_data[k] = regs[i_rd_addr[k]].
  - Address >= DEPTH returns 0.
  - With ZERO_REG = 1, address 0 always returns 0.
- Writes (RUN state only):
  - Each enabled port commits on the rising edge; the value is visible on reads the following cycle.
  - Writes to address >= DEPTH are dropped.
  - With ZERO_REG = 1, writes to address 0 are dropped.
  - If both ports are enabled with the same address, port 1 wins and port 0's write is discarded.
  - If the addresses differ, both writes commit in the same edge.
- FSM states: RUN and CLEAR.
  - RUN to CLEAR: on an edge where i_clr = 1.
    - Writes presented in that same cycle still commit.
    - Clear index is loaded with 0.
    - o_ready falls to 0 from the next cycle.
  - In CLEAR, each edge writes 0 to regs[index] and increments index. The sweep takes exactly DEPTH cycles.
  - During CLEAR:
    - i_we0 and i_we1 are ignored and their data is lost; upstream must stall on o_ready = 0.
    - i_clr is ignored; the sweep does not restart.
    - o_rd_data returns 0 on all ports, regardless of sweep progress.
  - CLEAR to RUN: on the edge that clears index DEPTH-1. o_ready = 1 and writes are accepted from the next cycle.
  - Reset mid-sweep aborts the sweep; the bank goes to RUN with all registers 0.
- Index counter: AW+1 bits wide, so there is no wrap-around ambiguity when DEPTH is a power of two.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - In RUN, a read whose address matches an enabled, non-dropped write in the same cycle returns that write's data combinationally.
  - If both write ports match, port 1's data is returned.
  - A dropped write (address 0 with ZERO_REG = 1, or address >= DEPTH) is never bypassed.
  - No bypass occurs in CLEAR.
- Undefined: reads always return the stored value, which is the pre-write value during the write cycle.

Test Plan:
1. Reset, then write 0xDEADBEEF to reg 5 via port 0 and read reg 5 on port 1 the next cycle -> 0xDEADBEEF. Read reg 5 during the write cycle -> 0 without the macro, 0xDEADBEEF with REGBANK_BYPASS_EN.
2. Same-cycle collision: port 0 writes 0x11111111 and port 1 writes 0x22222222, both to reg 9 -> reg 9 reads 0x22222222. Separately, port 0 to reg 3 (0xA) and port 1 to reg 4 (0xB) in one cycle -> both values present.
3. ZERO_REG = 1: write 0xFFFFFFFF to reg 0 -> reads 0, with or without bypass. With ZERO_REG = 0 the same write -> reads 0xFFFFFFFF.
4. Fill regs 1..31 with their own index, pulse i_clr -> o_ready is low for exactly 32 cycles. A write to reg 7 mid-sweep is lost, and a second i_clr mid-sweep is ignored. Afterwards all registers read 0 and o_ready = 1.
5. Assert i_rst asynchronously (between edges) at sweep cycle 10 -> o_ready = 1 and all reads 0 before the next clock edge. A write to reg 2 (0x55) on the following edge is accepted.
6. DEPTH = 20, NUM_RD = 3: write 0x77 to address 25 -> dropped, and reading address 25 returns 0. Write 0x5A to reg 19 -> all three read ports return 0x5A.
